// File: rtl/hv_timing_gen.sv
// ---------------------------------------------------------------------------
// hv_timing_gen -- parametrised video timing generator for arcade cores.
//
// Produces the pixel/line counters, blanking flags, active-low syncs, line
// and frame strobes, plus a blanked RGB output that lags the core pixel by
// one pixel enable. The display-enable output DE lags by the same amount.
// The sync windows can be shifted at run time. Offset changes take effect
// only at the next frame boundary, so a frame is never torn.
//
// Optional feature (compile-time macro HVGEN_FLIP_EN):
//   adds input FLIP. When FLIP is set, the visible part of HPOS/VPOS is
//   mirrored for cocktail cabinets. FLIP is latched together with the offsets.
//
// Ports:
//   CLK          clock for all logic
//   RESET        synchronous, active-high reset (has priority over CE)
//   CE           pixel enable; state only advances when CE=1
//   H_OFS/V_OFS  signed 4-bit sync shifts (positive = picture right/down)
//   FLIP         (HVGEN_FLIP_EN only) mirror the position outputs
//   HPOS/VPOS    pixel / line position for the core
//   HBLK/VBLK    blanking flags for the presented position
//   HSYN/VSYN    active-low syncs
//   LSTART       one-CLK pulse after the CE that enters hcnt=0
//   FSTART       one-CLK pulse after the CE that enters hcnt=0, vcnt=0
//   iRGB         core pixel for the current HPOS/VPOS
//   oRGB         blanked pixel, one CE late
//   DE           ~(HBLK|VBLK), aligned with oRGB
// ---------------------------------------------------------------------------
module hv_timing_gen #(
   parameter int H_ACTIVE     = 288,
   parameter int H_SYNC_START = 311,
   parameter int H_SYNC_END   = 342,
   parameter int H_TOTAL      = 384,
   parameter int V_ACTIVE     = 224,
   parameter int V_SYNC_START = 227,
   parameter int V_SYNC_END   = 234,
   parameter int V_TOTAL      = 264,
   parameter int CW           = 9,
   parameter int RGB_W        = 12
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             CE,
   input  logic [3:0]       H_OFS,
   input  logic [3:0]       V_OFS,
`ifdef HVGEN_FLIP_EN
   input  logic             FLIP,
`endif
   output logic [CW-1:0]    HPOS,
   output logic [CW-1:0]    VPOS,
   output logic             HBLK,
   output logic             VBLK,
   output logic             HSYN,
   output logic             VSYN,
   output logic             LSTART,
   output logic             FSTART,
   input  logic [RGB_W-1:0] iRGB,
   output logic [RGB_W-1:0] oRGB,
   output logic             DE
);

   localparam int CW1 = CW + 1;

   localparam logic [CW-1:0]        H_LAST_C   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0]        V_LAST_C   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0]        H_ACT_C    = CW'(H_ACTIVE);
   localparam logic [CW-1:0]        V_ACT_C    = CW'(V_ACTIVE);
   localparam logic [CW-1:0]        H_ACT_M1_C = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0]        V_ACT_M1_C = CW'(V_ACTIVE - 1);
   localparam logic [CW-1:0]        ONE_C      = CW'(1);
   localparam logic signed [CW:0]   H_SS_C     = CW1'(H_SYNC_START);
   localparam logic signed [CW:0]   H_SE_C     = CW1'(H_SYNC_END);
   localparam logic signed [CW:0]   V_SS_C     = CW1'(V_SYNC_START);
   localparam logic signed [CW:0]   V_SE_C     = CW1'(V_SYNC_END);

   // Active-low sync decode. The window bounds are shifted by the signed
   // offset in CW+1 bits with no wrap, so a window that falls partly or
   // fully outside 0..TOTAL-1 is simply truncated.
   function automatic logic sync_n(input logic [CW-1:0]      cnt,
                                   input logic signed [CW:0] start,
                                   input logic signed [CW:0] stop,
                                   input logic [3:0]         ofs);
      logic signed [CW:0] ofs_x;
      logic signed [CW:0] pos_x;
      logic signed [CW:0] lo_x;
      logic signed [CW:0] hi_x;
      ofs_x = {{(CW - 3){ofs[3]}}, ofs};
      pos_x = {1'b0, cnt};
      lo_x  = start - ofs_x;
      hi_x  = stop - ofs_x;
      return !((pos_x >= lo_x) && (pos_x < hi_x));
   endfunction

   // Cocktail mirror: only the visible range is reflected.
   function automatic logic [CW-1:0] mirror(input logic [CW-1:0] cnt,
                                            input logic [CW-1:0] act,
                                            input logic [CW-1:0] act_m1,
                                            input logic          en);
      return (en && (cnt < act)) ? (act_m1 - cnt) : cnt;
   endfunction

   logic [CW-1:0]    hcnt_q, hcnt_d;
   logic [CW-1:0]    vcnt_q, vcnt_d;
   logic [3:0]       hofs_q, hofs_d;
   logic [3:0]       vofs_q, vofs_d;
   logic             flip_d;
`ifdef HVGEN_FLIP_EN
   logic             flip_q;
`endif
   logic             line_end_s;
   logic             frame_end_s;
   logic [CW-1:0]    hpos_q, vpos_q;
   logic             hblk_q, vblk_q, hsyn_q, vsyn_q;
   logic             lstart_q, fstart_q;
   logic [RGB_W-1:0] rgb_q;
   logic             de_q;

   // Next-state counters and frame-boundary latching of offsets/flip.
   always_comb begin
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      hofs_d      = hofs_q;
      vofs_d      = vofs_q;
`ifdef HVGEN_FLIP_EN
      flip_d      = flip_q;
`else
      flip_d      = 1'b0;
`endif
      line_end_s  = 1'b0;
      frame_end_s = 1'b0;
      if (CE) begin
         line_end_s  = (hcnt_q == H_LAST_C);
         frame_end_s = line_end_s && (vcnt_q == V_LAST_C);
         if (line_end_s) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST_C) begin
               vcnt_d = '0;
            end else begin
               vcnt_d = vcnt_q + ONE_C;
            end
         end else begin
            hcnt_d = hcnt_q + ONE_C;
         end
         // New settings apply from pixel (0,0) of the next frame onward.
         if (frame_end_s) begin
            hofs_d = H_OFS;
            vofs_d = V_OFS;
`ifdef HVGEN_FLIP_EN
            flip_d = FLIP;
`else
            flip_d = 1'b0;
`endif
         end else begin
            hofs_d = hofs_q;
            vofs_d = vofs_q;
         end
      end else begin
         hcnt_d = hcnt_q;
         vcnt_d = vcnt_q;
      end
   end

   // State and output registers; the flags are decoded from the next-state
   // counters so they line up with the HPOS/VPOS presented in the same cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         hofs_q   <= 4'd0;
         vofs_q   <= 4'd0;
`ifdef HVGEN_FLIP_EN
         flip_q   <= 1'b0;
`endif
         hpos_q   <= '0;
         vpos_q   <= '0;
         hblk_q   <= 1'b0;
         vblk_q   <= 1'b0;
         hsyn_q   <= 1'b1;
         vsyn_q   <= 1'b1;
         lstart_q <= 1'b0;
         fstart_q <= 1'b0;
         rgb_q    <= '0;
         de_q     <= 1'b0;
      end else begin
         // Strobes are one CLK wide and fall while CE is low.
         lstart_q <= line_end_s;
         fstart_q <= frame_end_s;
         if (CE) begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hofs_q <= hofs_d;
            vofs_q <= vofs_d;
`ifdef HVGEN_FLIP_EN
            flip_q <= flip_d;
`endif
            hpos_q <= mirror(hcnt_d, H_ACT_C, H_ACT_M1_C, flip_d);
            vpos_q <= mirror(vcnt_d, V_ACT_C, V_ACT_M1_C, flip_d);
            hblk_q <= (hcnt_d >= H_ACT_C);
            vblk_q <= (vcnt_d >= V_ACT_C);
            hsyn_q <= sync_n(hcnt_d, H_SS_C, H_SE_C, hofs_d);
            vsyn_q <= sync_n(vcnt_d, V_SS_C, V_SE_C, vofs_d);
            // Blank with the flags of the pixel being sampled now.
            rgb_q  <= (hblk_q | vblk_q) ? '0 : iRGB;
            de_q   <= ~(hblk_q | vblk_q);
         end
      end
   end

   assign HPOS   = hpos_q;
   assign VPOS   = vpos_q;
   assign HBLK   = hblk_q;
   assign VBLK   = vblk_q;
   assign HSYN   = hsyn_q;
   assign VSYN   = vsyn_q;
   assign LSTART = lstart_q;
   assign FSTART = fstart_q;
   assign oRGB   = rgb_q;
   assign DE     = de_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
`timescale 1ns/1ps
module tb_hv_timing_gen;

   localparam int RW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // DUT0: default parameters
   logic          rst0, ce0, flip0;
   logic [3:0]    hofs0, vofs0;
   logic [RW-1:0] irgb0, orgb0;
   logic [8:0]    hpos0, vpos0;
   logic          hblk0, vblk0, hsyn0, vsyn0, ls0, fs0, de0;

   // DUT1: small geometry 16x8
   logic          rst1, ce1, flip1;
   logic [3:0]    hofs1, vofs1;
   logic [RW-1:0] irgb1, orgb1;
   logic [8:0]    hpos1, vpos1;
   logic          hblk1, vblk1, hsyn1, vsyn1, ls1, fs1, de1;

   hv_timing_gen dut0 (
      .CLK(clk), .RESET(rst0), .CE(ce0), .H_OFS(hofs0), .V_OFS(vofs0),
`ifdef HVGEN_FLIP_EN
      .FLIP(flip0),
`endif
      .HPOS(hpos0), .VPOS(vpos0), .HBLK(hblk0), .VBLK(vblk0),
      .HSYN(hsyn0), .VSYN(vsyn0), .LSTART(ls0), .FSTART(fs0),
      .iRGB(irgb0), .oRGB(orgb0), .DE(de0)
   );

   hv_timing_gen #(
      .H_ACTIVE(10), .H_SYNC_START(12), .H_SYNC_END(14), .H_TOTAL(16),
      .V_ACTIVE(6), .V_SYNC_START(6), .V_SYNC_END(7), .V_TOTAL(8)
   ) dut1 (
      .CLK(clk), .RESET(rst1), .CE(ce1), .H_OFS(hofs1), .V_OFS(vofs1),
`ifdef HVGEN_FLIP_EN
      .FLIP(flip1),
`endif
      .HPOS(hpos1), .VPOS(vpos1), .HBLK(hblk1), .VBLK(vblk1),
      .HSYN(hsyn1), .VSYN(vsyn1), .LSTART(ls1), .FSTART(fs1),
      .iRGB(irgb1), .oRGB(orgb1), .DE(de1)
   );

   typedef struct packed {
      int ha; int hss; int hse; int ht;
      int va; int vss; int vse; int vt;
   } cfg_t;

   typedef struct packed {
      int h; int v; int ho; int vo;
      logic flip; logic hb; logic vb; logic hs; logic vs;
      logic ls; logic fs; logic de;
      logic [RW-1:0] rgb;
   } mst_t;

   typedef struct packed {
      logic [8:0] hpos; logic [8:0] vpos;
      logic hb; logic vb; logic hs; logic vs; logic ls; logic fs; logic de;
      logic [RW-1:0] rgb;
   } obs_t;

   typedef struct {
      int ho; int vo; int hs_lo; int hs_hi; int vs_lo; int vs_hi;
   } vec_t;

   cfg_t c0, c1;
   mst_t ms0, ms1;
   obs_t q0[$];
   obs_t q1[$];

   // Behavioural reference: one CLK of the timing generator.
   function automatic mst_t mstep(input cfg_t c, input mst_t s, input logic rst,
                                  input logic ce, input logic [3:0] ho,
                                  input logic [3:0] vo, input logic fl,
                                  input logic [RW-1:0] rgb);
      mst_t n;
      n = s;
      if (rst) begin
         n    = '0;
         n.hs = 1'b1;
         n.vs = 1'b1;
      end else begin
         n.ls = 1'b0;
         n.fs = 1'b0;
         if (ce) begin
            n.de  = ~(s.hb | s.vb);
            n.rgb = n.de ? rgb : '0;
            if (s.h == c.ht - 1) begin
               n.ls = 1'b1;
               n.h  = 0;
               if (s.v == c.vt - 1) begin
                  n.fs   = 1'b1;
                  n.v    = 0;
                  n.ho   = int'($signed(ho));
                  n.vo   = int'($signed(vo));
                  n.flip = fl;
               end else begin
                  n.v = s.v + 1;
               end
            end else begin
               n.h = s.h + 1;
            end
            n.hb = (n.h >= c.ha);
            n.vb = (n.v >= c.va);
            n.hs = ~((n.h >= c.hss - n.ho) && (n.h < c.hse - n.ho));
            n.vs = ~((n.v >= c.vss - n.vo) && (n.v < c.vse - n.vo));
         end
      end
      return n;
   endfunction

   function automatic obs_t m_obs(input cfg_t c, input mst_t s);
      obs_t o;
      int hp, vp;
      hp = (s.flip && s.h < c.ha) ? c.ha - 1 - s.h : s.h;
      vp = (s.flip && s.v < c.va) ? c.va - 1 - s.v : s.v;
      o.hpos = hp[8:0];
      o.vpos = vp[8:0];
      o.hb = s.hb; o.vb = s.vb; o.hs = s.hs; o.vs = s.vs;
      o.ls = s.ls; o.fs = s.fs; o.de = s.de; o.rgb = s.rgb;
      return o;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock: model predicts, push; edge; pop and compare both DUTs.
   task automatic tick();
      obs_t e, a;
      irgb0 = RW'($urandom);
      irgb1 = RW'($urandom);
      ms0 = mstep(c0, ms0, rst0, ce0, hofs0, vofs0, flip0, irgb0);
      ms1 = mstep(c1, ms1, rst1, ce1, hofs1, vofs1, flip1, irgb1);
      q0.push_back(m_obs(c0, ms0));
      q1.push_back(m_obs(c1, ms1));
      @(posedge clk);
      #1;
      e = q0.pop_front();
      a = {hpos0, vpos0, hblk0, vblk0, hsyn0, vsyn0, ls0, fs0, de0, orgb0};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL sb_dut0: got %h expected %h", a, e);
      end
      e = q1.pop_front();
      a = {hpos1, vpos1, hblk1, vblk1, hsyn1, vsyn1, ls1, fs1, de1, orgb1};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL sb_dut1: got %h expected %h", a, e);
      end
   endtask

   initial begin
      vec_t tbl[8];
      int hb_rise, hs_lo, hs_hi, vs_lo, vs_hi, ls_prev, ls_cnt, viol, n;
      logic ls_last, found;

      c0 = '{288, 311, 342, 384, 224, 227, 234, 264};
      c1 = '{10, 12, 14, 16, 6, 6, 7, 8};
      ms0 = '0;
      ms1 = '0;

      // {H_OFS, V_OFS, hsync lo..hi, vsync lo..hi}; -1 = never low
      tbl[0] = '{ 0,  0, 12, 13,  6,  6};
      tbl[1] = '{-7,  0, -1, -1,  6,  6};
      tbl[2] = '{ 3, -2,  9, 10, -1, -1};
      tbl[3] = '{ 7,  1,  5,  6,  5,  5};
      tbl[4] = '{-8,  5, -1, -1,  1,  1};
      tbl[5] = '{ 2, -1, 10, 11,  7,  7};
      tbl[6] = '{-3,  6, 15, 15,  0,  0};
      tbl[7] = '{ 0, -7, 12, 13, -1, -1};

      rst0 = 1'b1; ce0 = 1'b1; hofs0 = 4'd0; vofs0 = 4'd0; flip0 = 1'b0; irgb0 = '0;
      rst1 = 1'b1; ce1 = 1'b1; hofs1 = 4'd0; vofs1 = 4'd0; flip1 = 1'b0; irgb1 = '0;
      tick();
      tick();

      // Reset state
      chk("rst_hpos", int'(hpos0), 0);
      chk("rst_vpos", int'(vpos0), 0);
      chk("rst_hsyn", int'(hsyn0), 1);
      chk("rst_vsyn", int'(vsyn0), 1);
      chk("rst_hblk", int'(hblk0), 0);
      chk("rst_de",   int'(de0), 0);
      chk("rst_orgb", int'(orgb0), 0);
      chk("rst_lstart", int'(ls0), 0);

      // Default geometry, CE=1, three lines
      rst0 = 1'b0;
      rst1 = 1'b0;
      hb_rise = -1; hs_lo = 999; hs_hi = -1; ls_prev = -1; ls_cnt = 0;
      for (int i = 0; i < 3 * 384 + 2; i++) begin
         tick();
         if (hblk0 && hb_rise < 0) hb_rise = int'(hpos0);
         if (!hsyn0 && vpos0 == 9'd0) begin
            if (int'(hpos0) < hs_lo) hs_lo = int'(hpos0);
            if (int'(hpos0) > hs_hi) hs_hi = int'(hpos0);
         end
         if (ls0) begin
            chk("lstart_at_h0", int'(hpos0), 0);
            if (ls_prev >= 0) chk("lstart_period", i - ls_prev, 384);
            ls_prev = i;
            ls_cnt++;
         end
      end
      chk("hblk_rise", hb_rise, 288);
      chk("hsyn_lo", hs_lo, 311);
      chk("hsyn_hi", hs_hi, 341);
      chk("lstart_count", ls_cnt, 3);

      // Small geometry: sync window per offset pair, applied mid-frame
      for (int k = 0; k < 8; k++) begin
         hofs1 = tbl[k].ho[3:0];
         vofs1 = tbl[k].vo[3:0];
         for (int i = 0; i < 5; i++) tick();
         found = 1'b0;
         for (int i = 0; i < 300 && !found; i++) begin
            tick();
            found = fs1;
         end
         chk("tbl_fstart_seen", int'(found), 1);
         hs_lo = 999; hs_hi = -1; vs_lo = 999; vs_hi = -1;
         for (int i = 0; i < 128; i++) begin
            if (!hsyn1) begin
               if (int'(hpos1) < hs_lo) hs_lo = int'(hpos1);
               if (int'(hpos1) > hs_hi) hs_hi = int'(hpos1);
            end
            if (!vsyn1) begin
               if (int'(vpos1) < vs_lo) vs_lo = int'(vpos1);
               if (int'(vpos1) > vs_hi) vs_hi = int'(vpos1);
            end
            tick();
         end
         if (hs_lo == 999) hs_lo = -1;
         if (vs_lo == 999) vs_lo = -1;
         chk($sformatf("tbl%0d_hs_lo", k), hs_lo, tbl[k].hs_lo);
         chk($sformatf("tbl%0d_hs_hi", k), hs_hi, tbl[k].hs_hi);
         chk($sformatf("tbl%0d_vs_lo", k), vs_lo, tbl[k].vs_lo);
         chk($sformatf("tbl%0d_vs_hi", k), vs_hi, tbl[k].vs_hi);
      end
      hofs1 = 4'd0;
      vofs1 = 4'd0;

      // CE every 4th CLK on the default geometry
      viol = 0; ls_last = 1'b0; ls_cnt = 0;
      for (int i = 0; i < 4 * 400; i++) begin
         ce0 = (i % 4 == 0);
         tick();
         if (ls0 && ls_last) viol++;
         if (ls0) ls_cnt++;
         ls_last = ls0;
      end
      ce0 = 1'b1;
      chk("strobe_width", viol, 0);
      chk("lstart_slow_count", ls_cnt, 1);

      // Reset in mid-frame at HPOS=100, VPOS=50
      found = 1'b0;
      for (int i = 0; i < 25000 && !found; i++) begin
         tick();
         found = (hpos0 == 9'd100) && (vpos0 == 9'd50);
      end
      chk("reach_100_50", int'(found), 1);
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      chk("mrst_hpos", int'(hpos0), 0);
      chk("mrst_vpos", int'(vpos0), 0);
      chk("mrst_hsyn", int'(hsyn0), 1);
      chk("mrst_vsyn", int'(vsyn0), 1);
      chk("mrst_orgb", int'(orgb0), 0);
      chk("mrst_de",   int'(de0), 0);

      // Small geometry: first FSTART one full frame after a mid-frame reset
      for (int i = 0; i < 37; i++) tick();
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      n = 0;
      found = 1'b0;
      while (n < 400 && !found) begin
         tick();
         n++;
         found = fs1;
      end
      chk("fstart_after_reset", n, 128);
      chk("fstart_ls", int'(ls1), 1);

`ifdef HVGEN_FLIP_EN
      // Cocktail flip on the small geometry
      flip1 = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         tick();
         found = fs1;
      end
      chk("flip_fstart_seen", int'(found), 1);
      chk("flip_hpos0", int'(hpos1), 9);
      chk("flip_vpos0", int'(vpos1), 5);
      for (int i = 0; i < 12; i++) tick();
      chk("flip_hpos12", int'(hpos1), 12);
      chk("flip_hsyn12", int'(hsyn1), 0);
      for (int i = 0; i < 200; i++) tick();
      flip1 = 1'b0;
`endif

      for (int i = 0; i < 20; i++) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
